// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the memory arbiter.
// FSM states, port owner and latched command bundle.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } mem_cmd_t;

  localparam logic [31:0] ADDR_WMASK = 32'hFFFF_FFFC;
  localparam logic [3:0]  MASK_ALL   = 4'b1111;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return a & ADDR_WMASK;
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: fetch/data arbitration with data streak limit.
// Ports: i_sample (IDLE), i_if_req, i_dm_req -> o_valid, o_sel_dm.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int DSTREAK_MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sample,
  input  logic i_if_req,
  input  logic i_dm_req,
  output logic o_valid,
  output logic o_sel_dm
);

  localparam int CW =
    (DSTREAK_MAX < 1) ? 1 : $clog2(DSTREAK_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(DSTREAK_MAX);

  logic [CW-1:0] r_streak;
  logic          w_if_turn;
  logic          w_dm_win;

  // Fetch only overrides data once the streak is exhausted.
  assign w_if_turn = i_if_req && (r_streak == SMAX);
  assign w_dm_win  = i_dm_req && !w_if_turn;
  assign o_valid   = i_if_req | i_dm_req;
  assign o_sel_dm  = w_dm_win;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_streak <= '0;
    end else if (i_sample) begin
      if (!i_if_req) begin
        r_streak <= '0;
      end else if (!w_dm_win) begin
        r_streak <= '0;
      end else if (r_streak != SMAX) begin
        r_streak <= r_streak + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-outstanding fetch/data memory arbiter.
// Ports: fetch i_if_*/o_if_*, data i_dm_*/o_dm_*, memory o_mem_*/i_mem_*, o_busy.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DSTREAK_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_valid,
  output logic [31:0] o_if_rdata,
  input  logic        i_dm_req,
  input  logic        i_dm_wen,
  input  logic [31:0] i_dm_addr,
  input  logic [31:0] i_dm_wdata,
  input  logic [3:0]  i_dm_mask,
  output logic        o_dm_gnt,
  output logic        o_dm_valid,
  output logic [31:0] o_dm_rdata,
  output logic        o_mem_req,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_ready,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy
);

  arb_state_e r_state;
  owner_e     r_owner;
  mem_cmd_t   r_cmd;
  logic       r_mem_req;
  logic       r_if_gnt;
  logic       r_dm_gnt;
  logic       r_if_valid;
  logic       r_dm_valid;
  logic [31:0] r_if_rdata;
  logic [31:0] r_dm_rdata;

  logic w_idle;
  logic w_sel_valid;
  logic w_sel_dm;

  assign w_idle = (r_state == ST_IDLE);

  mem_arb_prio #(
    .DSTREAK_MAX(DSTREAK_MAX)
  ) u_prio (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_sample (w_idle),
    .i_if_req (i_if_req),
    .i_dm_req (i_dm_req),
    .o_valid  (w_sel_valid),
    .o_sel_dm (w_sel_dm)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_owner    <= OWN_IF;
      r_cmd      <= '0;
      r_mem_req  <= 1'b0;
      r_if_gnt   <= 1'b0;
      r_dm_gnt   <= 1'b0;
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_if_gnt   <= 1'b0;
      r_dm_gnt   <= 1'b0;
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_sel_valid) begin
            r_mem_req <= 1'b1;
            r_state   <= ST_ISSUE;
            if (w_sel_dm) begin
              r_owner     <= OWN_DM;
              r_dm_gnt    <= 1'b1;
              r_cmd.wen   <= i_dm_wen;
              r_cmd.addr  <= word_align(i_dm_addr);
              r_cmd.wdata <= i_dm_wdata;
              r_cmd.mask  <= i_dm_mask;
            end else begin
              r_owner     <= OWN_IF;
              r_if_gnt    <= 1'b1;
              r_cmd.wen   <= 1'b0;
              r_cmd.addr  <= word_align(i_if_addr);
              r_cmd.wdata <= '0;
              r_cmd.mask  <= MASK_ALL;
            end
          end
        end
        ST_ISSUE: begin
          // Response in the accept cycle is not taken.
          if (i_mem_ready) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_mem_valid) begin
            r_state <= ST_RESP;
            if (r_owner == OWN_DM) begin
              r_dm_valid <= 1'b1;
              r_dm_rdata <= i_mem_rdata;
            end else begin
              r_if_valid <= 1'b1;
              r_if_rdata <= i_mem_rdata;
            end
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_if_gnt    = r_if_gnt;
  assign o_dm_gnt    = r_dm_gnt;
  assign o_if_valid  = r_if_valid;
  assign o_dm_valid  = r_dm_valid;
  assign o_if_rdata  = r_if_rdata;
  assign o_dm_rdata  = r_dm_rdata;
  assign o_mem_req   = r_mem_req;
  assign o_mem_wen   = r_cmd.wen;
  assign o_mem_addr  = r_cmd.addr;
  assign o_mem_wdata = r_cmd.wdata;
  assign o_mem_mask  = r_cmd.mask;
  assign o_busy      = !w_idle;

endmodule
